// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I control path.
//   - opcode constants for the supported instruction subset
//   - FSM state, ALUOp, immediate-type and result-select enums
//   - ALU control codes and the opcode -> immediate-type decode
package pa_riscv;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } ty_state;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } ty_aluOp;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } ty_immSrc;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10
  } ty_resultSrc;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  function automatic ty_immSrc imm_src(input logic [6:0] opcode);
    case (opcode)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode from ALUOp and instruction fields.
//   i_aluOp      ALUOp from the main FSM
//   i_funct3     instr[14:12]
//   i_opb5       instr[5]: distinguishes R-type (1) from I-type (0)
//   i_funct7b5   instr[30]
//   o_aluControl ALU operation code
module alu_decoder
  import pa_riscv::*;
(
  input  ty_aluOp    i_aluOp,
  input  logic [2:0] i_funct3,
  input  logic       i_opb5,
  input  logic       i_funct7b5,
  output logic [2:0] o_aluControl
);

  always_comb begin
    o_aluControl = ALU_ADD;
    case (i_aluOp)
      ALUOP_SUB:   o_aluControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          // addi never subtracts, even with instr[30] set
          3'b000:  o_aluControl = (i_opb5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_aluControl = ALU_SLT;
          3'b110:  o_aluControl = ALU_OR;
          3'b111:  o_aluControl = ALU_AND;
          default: o_aluControl = ALU_ADD;
        endcase
      end
      default:     o_aluControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I subset (lw, sw, R, I-ALU, beq, jal).
// All outputs are combinational from state and inputs.
//   i_clk, i_arst_n          clock, async active-low reset
//   i_opcode/funct3/funct7b5 instruction fields from the IR
//   i_zero, i_memReady       ALU zero flag, memory completion handshake
//   o_*                      datapath enables/selects, ALU op, immSrc,
//                            retire and illegal-opcode pulses
//
// state      | meaning
// -----------+------------------------------------------------
// FETCH      | read instr at PC, PC+4 -> PC when memory ready
// DECODE     | read regs, oldPC+imm -> ALUOut, dispatch
// MEMADR     | rs1+imm -> ALUOut (load/store address)
// MEMREAD    | read memory at ALUOut until ready
// MEMWB      | load data -> rd
// MEMWRITE   | write memory at ALUOut until ready
// EXECUTER   | rs1 op rs2
// EXECUTEI   | rs1 op imm
// ALUWB      | ALUOut -> rd
// BEQ        | rs1-rs2, take branch target from ALUOut if zero
// JAL        | ALUOut (target) -> PC, oldPC+4 -> ALUOut
module multicycle_controller
  import pa_riscv::*;
(
  input  logic       i_clk,
  input  logic       i_arst_n,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  input  logic       i_memReady,
  output logic       o_pcWrite,
  output logic       o_adrSrc,
  output logic       o_memWrite,
  output logic       o_irWrite,
  output logic [1:0] o_resultSrc,
  output logic [1:0] o_aluSrcA,
  output logic [1:0] o_aluSrcB,
  output logic [2:0] o_aluControl,
  output logic       o_regWrite,
  output logic [1:0] o_immSrc,
  output logic       o_retired,
  output logic       o_illegal
);

  ty_state state_q, state_d;
  ty_aluOp aluOp;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) state_q <= S_FETCH;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    aluOp       = ALUOP_ADD;
    o_pcWrite   = 1'b0;
    o_adrSrc    = 1'b0;
    o_memWrite  = 1'b0;
    o_irWrite   = 1'b0;
    o_resultSrc = RES_ALUOUT;
    o_aluSrcA   = 2'b00;
    o_aluSrcB   = 2'b00;
    o_regWrite  = 1'b0;
    o_retired   = 1'b0;
    o_illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        o_aluSrcB   = 2'b10;
        o_resultSrc = RES_ALURESULT;
        // memReady is ignored while reset is held, so PC/IR stay untouched
        o_pcWrite   = i_memReady && i_arst_n;
        o_irWrite   = i_memReady && i_arst_n;
        if (i_memReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        o_aluSrcA = 2'b01;
        o_aluSrcB = 2'b01;
        case (i_opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_ITYPE:     state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            o_illegal = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        o_aluSrcA = 2'b10;
        o_aluSrcB = 2'b01;
        state_d   = (i_opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        o_adrSrc = 1'b1;
        if (i_memReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        o_resultSrc = RES_DATA;
        o_regWrite  = 1'b1;
        o_retired   = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        o_adrSrc   = 1'b1;
        o_memWrite = 1'b1;
        if (i_memReady) begin
          o_retired = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_EXECUTER: begin
        o_aluSrcA = 2'b10;
        aluOp     = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        o_aluSrcA = 2'b10;
        o_aluSrcB = 2'b01;
        aluOp     = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        o_regWrite = 1'b1;
        o_retired  = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ: begin
        o_aluSrcA = 2'b10;
        aluOp     = ALUOP_SUB;
        o_pcWrite = i_zero;
        o_retired = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        o_aluSrcA = 2'b01;
        o_aluSrcB = 2'b10;
        o_pcWrite = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign o_immSrc = imm_src(i_opcode);

  alu_decoder u_alu_decoder (
    .i_aluOp      (aluOp),
    .i_funct3     (i_funct3),
    .i_opb5       (i_opcode[5]),
    .i_funct7b5   (i_funct7b5),
    .o_aluControl (o_aluControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic       i_clk = 1'b0;
  logic       i_arst_n;
  logic [6:0] i_opcode;
  logic [2:0] i_funct3;
  logic       i_funct7b5;
  logic       i_zero;
  logic       i_memReady;
  logic       o_pcWrite, o_adrSrc, o_memWrite, o_irWrite;
  logic [1:0] o_resultSrc, o_aluSrcA, o_aluSrcB, o_immSrc;
  logic [2:0] o_aluControl;
  logic       o_regWrite, o_retired, o_illegal;

  int checks   = 0;
  int failures = 0;

  logic [17:0] sb_q[$];
  string       nm_q[$];

  always #5 i_clk = ~i_clk;

  multicycle_controller dut (
    .i_clk        (i_clk),
    .i_arst_n     (i_arst_n),
    .i_opcode     (i_opcode),
    .i_funct3     (i_funct3),
    .i_funct7b5   (i_funct7b5),
    .i_zero       (i_zero),
    .i_memReady   (i_memReady),
    .o_pcWrite    (o_pcWrite),
    .o_adrSrc     (o_adrSrc),
    .o_memWrite   (o_memWrite),
    .o_irWrite    (o_irWrite),
    .o_resultSrc  (o_resultSrc),
    .o_aluSrcA    (o_aluSrcA),
    .o_aluSrcB    (o_aluSrcB),
    .o_aluControl (o_aluControl),
    .o_regWrite   (o_regWrite),
    .o_immSrc     (o_immSrc),
    .o_retired    (o_retired),
    .o_illegal    (o_illegal)
  );

  // Packed order: pcWrite adrSrc memWrite irWrite resultSrc aluSrcA aluSrcB
  //               aluControl regWrite immSrc retired illegal
  function automatic logic [17:0] ev(input logic pc, adr, mw, ir,
                                     input logic [1:0] rs, a, b,
                                     input logic [2:0] alu,
                                     input logic rw,
                                     input logic [1:0] imm,
                                     input logic ret, ill);
    return {pc, adr, mw, ir, rs, a, b, alu, rw, imm, ret, ill};
  endfunction

  // Monitor: the controller presents a fresh control word every cycle.
  always @(negedge i_clk) begin
    if (sb_q.size() > 0) begin
      logic [17:0] exp_v, act_v;
      string       nm;
      exp_v = sb_q.pop_front();
      nm    = nm_q.pop_front();
      act_v = {o_pcWrite, o_adrSrc, o_memWrite, o_irWrite, o_resultSrc,
               o_aluSrcA, o_aluSrcB, o_aluControl, o_regWrite, o_immSrc,
               o_retired, o_illegal};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL %s: got=%b expected=%b", nm, act_v, exp_v);
      end
    end
  end

  // Drive one cycle's inputs (called at posedge+1) and queue its expected word.
  task automatic cyc(input string nm, input logic [6:0] op, input logic [2:0] f3,
                     input logic f7, input logic z, input logic r,
                     input logic [17:0] e);
    i_opcode   = op;
    i_funct3   = f3;
    i_funct7b5 = f7;
    i_zero     = z;
    i_memReady = r;
    sb_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge i_clk);
    #1;
  endtask

  // FETCH (ready) and DECODE words share a shape; only immSrc varies.
  function automatic logic [17:0] fetch_w(input logic r, input logic [1:0] imm);
    return ev(r, 0, 0, r, 2'b10, 2'b00, 2'b10, 3'b000, 0, imm, 0, 0);
  endfunction
  function automatic logic [17:0] dec_w(input logic [1:0] imm);
    return ev(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, imm, 0, 0);
  endfunction

  localparam logic [17:0] ALUWB_I = 18'b0_0_0_0_00_00_00_000_1_00_1_0;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, queue=%0d", sb_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    i_arst_n = 1'b0; i_opcode = 7'b0110011; i_funct3 = 3'b000;
    i_funct7b5 = 1'b1; i_zero = 1'b0; i_memReady = 1'b1;
    @(posedge i_clk); #1;

    // Reset held: FETCH encodings with no PC/IR writes despite ready
    cyc("rst_fetch", 7'b0110011, 3'b000, 1, 0, 1, fetch_w(0, 2'b00));
    i_arst_n = 1'b1;

    // R-type sub
    cyc("sub_fetch", 7'b0110011, 3'b000, 1, 0, 1, fetch_w(1, 2'b00));
    cyc("sub_dec",   7'b0110011, 3'b000, 1, 0, 1, dec_w(2'b00));
    cyc("sub_exe",   7'b0110011, 3'b000, 1, 0, 1, ev(0,0,0,0,2'b00,2'b10,2'b00,3'b001,0,2'b00,0,0));
    cyc("sub_wb",    7'b0110011, 3'b000, 1, 0, 1, ALUWB_I);

    // R-type slt
    cyc("slt_fetch", 7'b0110011, 3'b010, 0, 0, 1, fetch_w(1, 2'b00));
    cyc("slt_dec",   7'b0110011, 3'b010, 0, 0, 1, dec_w(2'b00));
    cyc("slt_exe",   7'b0110011, 3'b010, 0, 0, 1, ev(0,0,0,0,2'b00,2'b10,2'b00,3'b101,0,2'b00,0,0));
    cyc("slt_wb",    7'b0110011, 3'b010, 0, 0, 1, ALUWB_I);

    // addi with instr[30]=1 stays add
    cyc("addi_fetch", 7'b0010011, 3'b000, 1, 0, 1, fetch_w(1, 2'b00));
    cyc("addi_dec",   7'b0010011, 3'b000, 1, 0, 1, dec_w(2'b00));
    cyc("addi_exe",   7'b0010011, 3'b000, 1, 0, 1, ev(0,0,0,0,2'b00,2'b10,2'b01,3'b000,0,2'b00,0,0));
    cyc("addi_wb",    7'b0010011, 3'b000, 1, 0, 1, ALUWB_I);

    // ori
    cyc("ori_dec_f", 7'b0010011, 3'b110, 0, 0, 1, fetch_w(1, 2'b00));
    cyc("ori_dec",   7'b0010011, 3'b110, 0, 0, 1, dec_w(2'b00));
    cyc("ori_exe",   7'b0010011, 3'b110, 0, 0, 1, ev(0,0,0,0,2'b00,2'b10,2'b01,3'b011,0,2'b00,0,0));
    cyc("ori_wb",    7'b0010011, 3'b110, 0, 0, 1, ALUWB_I);

    // lw with 3 wait cycles in MEMREAD (8 cycles total)
    cyc("lw_fetch",  7'b0000011, 3'b010, 0, 0, 1, fetch_w(1, 2'b00));
    cyc("lw_dec",    7'b0000011, 3'b010, 0, 0, 1, dec_w(2'b00));
    cyc("lw_adr",    7'b0000011, 3'b010, 0, 0, 1, ev(0,0,0,0,2'b00,2'b10,2'b01,3'b000,0,2'b00,0,0));
    for (int i = 0; i < 3; i++)
      cyc("lw_read_wait", 7'b0000011, 3'b010, 0, 0, 0, ev(0,1,0,0,2'b00,2'b00,2'b00,3'b000,0,2'b00,0,0));
    cyc("lw_read_rdy", 7'b0000011, 3'b010, 0, 0, 1, ev(0,1,0,0,2'b00,2'b00,2'b00,3'b000,0,2'b00,0,0));
    cyc("lw_wb",     7'b0000011, 3'b010, 0, 0, 1, ev(0,0,0,0,2'b01,2'b00,2'b00,3'b000,1,2'b00,1,0));
    cyc("lw_next_fetch_stall", 7'b0000011, 3'b010, 0, 0, 0, fetch_w(0, 2'b00));

    // sw with 2 wait cycles in MEMWRITE
    cyc("sw_fetch",  7'b0100011, 3'b010, 0, 0, 1, fetch_w(1, 2'b01));
    cyc("sw_dec",    7'b0100011, 3'b010, 0, 0, 1, dec_w(2'b01));
    cyc("sw_adr",    7'b0100011, 3'b010, 0, 0, 1, ev(0,0,0,0,2'b00,2'b10,2'b01,3'b000,0,2'b01,0,0));
    for (int i = 0; i < 2; i++)
      cyc("sw_write_wait", 7'b0100011, 3'b010, 0, 0, 0, ev(0,1,1,0,2'b00,2'b00,2'b00,3'b000,0,2'b01,0,0));
    cyc("sw_write_rdy", 7'b0100011, 3'b010, 0, 0, 1, ev(0,1,1,0,2'b00,2'b00,2'b00,3'b000,0,2'b01,1,0));

    // beq taken / not taken
    cyc("beqt_fetch", 7'b1100011, 3'b000, 0, 1, 1, fetch_w(1, 2'b10));
    cyc("beqt_dec",   7'b1100011, 3'b000, 0, 1, 1, dec_w(2'b10));
    cyc("beqt_exe",   7'b1100011, 3'b000, 0, 1, 1, ev(1,0,0,0,2'b00,2'b10,2'b00,3'b001,0,2'b10,1,0));
    cyc("beqn_fetch", 7'b1100011, 3'b000, 0, 0, 1, fetch_w(1, 2'b10));
    cyc("beqn_dec",   7'b1100011, 3'b000, 0, 0, 1, dec_w(2'b10));
    cyc("beqn_exe",   7'b1100011, 3'b000, 0, 0, 1, ev(0,0,0,0,2'b00,2'b10,2'b00,3'b001,0,2'b10,1,0));

    // jal, then an unsupported opcode
    cyc("jal_fetch", 7'b1101111, 3'b000, 0, 0, 1, fetch_w(1, 2'b11));
    cyc("jal_dec",   7'b1101111, 3'b000, 0, 0, 1, dec_w(2'b11));
    cyc("jal_exe",   7'b1101111, 3'b000, 0, 0, 1, ev(1,0,0,0,2'b00,2'b01,2'b10,3'b000,0,2'b11,0,0));
    cyc("jal_wb",    7'b1101111, 3'b000, 0, 0, 1, ev(0,0,0,0,2'b00,2'b00,2'b00,3'b000,1,2'b11,1,0));
    cyc("ill_fetch", 7'b0000000, 3'b000, 0, 0, 1, fetch_w(1, 2'b00));
    cyc("ill_dec",   7'b0000000, 3'b000, 0, 0, 1, ev(0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,2'b00,0,1));
    cyc("ill_back_in_fetch", 7'b0000000, 3'b000, 0, 0, 0, fetch_w(0, 2'b00));

    // sw interrupted by async reset inside MEMWRITE
    cyc("swr_fetch", 7'b0100011, 3'b010, 0, 0, 1, fetch_w(1, 2'b01));
    cyc("swr_dec",   7'b0100011, 3'b010, 0, 0, 1, dec_w(2'b01));
    cyc("swr_adr",   7'b0100011, 3'b010, 0, 0, 1, ev(0,0,0,0,2'b00,2'b10,2'b01,3'b000,0,2'b01,0,0));
    cyc("swr_write_wait", 7'b0100011, 3'b010, 0, 0, 0, ev(0,1,1,0,2'b00,2'b00,2'b00,3'b000,0,2'b01,0,0));
    // now in MEMWRITE; drop reset mid-cycle with ready high
    i_memReady = 1'b1;
    sb_q.push_back(fetch_w(0, 2'b01));
    nm_q.push_back("swr_reset_mid");
    #1 i_arst_n = 1'b0;
    @(posedge i_clk); #1;
    cyc("swr_reset_hold", 7'b0100011, 3'b010, 0, 0, 1, fetch_w(0, 2'b01));
    i_arst_n = 1'b1;
    cyc("post_fetch", 7'b0010011, 3'b111, 0, 0, 1, fetch_w(1, 2'b00));
    cyc("post_dec",   7'b0010011, 3'b111, 0, 0, 1, dec_w(2'b00));
    cyc("post_exe",   7'b0010011, 3'b111, 0, 0, 1, ev(0,0,0,0,2'b00,2'b10,2'b01,3'b010,0,2'b00,0,0));
    cyc("post_wb",    7'b0010011, 3'b111, 0, 0, 1, ALUWB_I);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge i_clk);
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expected words never compared, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RV32I core subset: lw, sw, R-type, I-type ALU, beq, jal.
- Each instruction is sequenced over 3–5 cycles through one shared ALU, one unified memory port, the instruction register and the immediate extender.
- Drives every datapath mux/enable, the extender's immediate-type select and the ALU operation.
- Stalls on a memory ready handshake.

Parameters:
- None. All encodings are fixed by the shared package.

Ports:
- i_clk  in  1  system clock.
- i_arst_n  in  1  reset, asynchronous, active-low.
- i_opcode  in  7  instr[6:0] from the instruction register.
- i_funct3  in  3  instr[14:12].
- i_funct7b5  in  1  instr[30].
- i_zero  in  1  ALU zero flag.
- i_memReady  in  1  memory has completed the current read/write this cycle.
- o_pcWrite  out  1  PC register enable.
- o_adrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
- o_memWrite  out  1  memory write strobe.
- o_irWrite  out  1  instruction register / oldPC enable.
- o_resultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult.
- o_aluSrcA  out  2  ALU A select: 00=PC, 01=oldPC, 10=rs1 data.
- o_aluSrcB  out  2  ALU B select: 00=rs2 data, 01=immediate, 10=constant 4.
- o_aluControl  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- o_regWrite  out  1  register file write enable.
- o_immSrc  out  2  extender type: 00=I, 01=S, 10=B, 11=J.
- o_retired  out  1  one-cycle pulse when an instruction completes.
- o_illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_arst_n is asynchronous and active-low. While i_arst_n=0, state=FETCH.
- Control outputs are combinational from state plus inputs. Fields not listed for a state are 0.
- During reset all strobes are 0 except the FETCH encodings, and i_memReady is not sampled until reset is released.
- Reset asserted mid-instruction abandons the instruction; no partial writes occur after reset is asserted.
- FETCH: adrSrc=0, aluSrcA=00, aluSrcB=10, add, resultSrc=10.
  - irWrite and pcWrite assert only in the cycle i_memReady=1; the FSM then moves to DECODE.
  - Otherwise the FSM stays in FETCH and the PC/IR are not written.
- DECODE: aluSrcA=01, aluSrcB=01, add (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other opcode -> FETCH with o_illegal=1; no architectural state is written.
- MEMADR: aluSrcA=10, aluSrcB=01, add. Next state MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: adrSrc=1, resultSrc=00. Holds until i_memReady=1, then MEMWB.
- MEMWB: resultSrc=01, regWrite=1, o_retired=1. Next state FETCH.
- MEMWRITE: adrSrc=1, resultSrc=00.
  - memWrite=1 every cycle in this state.
  - Holds until i_memReady=1, then FETCH with o_retired=1 in that same ready cycle.
- EXECUTER: aluSrcA=10, aluSrcB=00, ALU decoded from ALUOp=10. Next state ALUWB.
- EXECUTEI: aluSrcA=10, aluSrcB=01, ALU decoded from ALUOp=10. Next state ALUWB.
- ALUWB: resultSrc=00, regWrite=1, o_retired=1. Next state FETCH.
- BEQ: aluSrcA=10, aluSrcB=00, sub, resultSrc=00, pcWrite=i_zero, o_retired=1. Next state FETCH.
- JAL: aluSrcA=01, aluSrcB=10, add, resultSrc=00, pcWrite=1. Next state ALUWB, which writes rd=PC+4 and asserts o_retired.
- Latency with i_memReady always 1:
  - lw: 5 cycles
  - sw, R-type, I-type, jal: 4 cycles
  - beq: 3 cycles
- o_immSrc is driven in all states, decoded from i_opcode:
  - 0000011 and 0010011 -> 00
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - any other opcode -> 00
- ALU decode:
  - ALUOp 00 -> add; ALUOp 01 -> sub.
  - ALUOp 10 with funct3 000: sub when i_opcode[5]=1 and i_funct7b5=1, else add. So addi with instr[30]=1 is still add.
  - ALUOp 10 with funct3 010 -> slt, 110 -> or, 111 -> and; any other funct3 -> add.
- Never simultaneously asserted: regWrite and memWrite; memWrite and irWrite.

Decomposition:
- pa_riscv package gains:
  - opcode constants LW, SW, RTYPE, ITYPE, BEQ, JAL (the existing I, S, B remain)
  - typedef enum logic [3:0] ty_state
  - typedef enum logic [1:0] ty_aluOp, ty_immSrc, ty_resultSrc
  - localparams for the ALU control codes.
- One combinational sub-module, alu_decoder (ALUOp, funct3, op[5], funct7b5 -> aluControl), instantiated by the FSM.

Test Plan:
- Reset held, then released with i_memReady=1 and opcode 0110011, funct3 000, funct7b5 1:
  - states FETCH, DECODE, EXECUTER, ALUWB.
  - aluControl=001 in EXECUTER; regWrite=1 only in ALUWB; o_retired pulses once.
- lw (0000011) with i_memReady=0 for 3 cycles in MEMREAD:
  - FSM stays in MEMREAD with adrSrc=1 throughout.
  - Total 8 cycles; MEMWB has resultSrc=01, regWrite=1.
- sw (0100011) with i_memReady low for 2 cycles in MEMWRITE:
  - memWrite=1 for all 3 cycles; immSrc=01; regWrite never asserted.
- beq (1100011):
  - with i_zero=1: pcWrite=1 in BEQ.
  - with i_zero=0: pcWrite=0.
  - Both take 3 cycles and return to FETCH.
- jal (1101111):
  - pcWrite=1 in JAL and immSrc=11.
  - ALUWB writes the register with resultSrc=00.
  - Then an unsupported opcode 0000000: o_illegal pulses in DECODE, next state FETCH, no regWrite or memWrite.
- i_arst_n dropped asynchronously mid-MEMWRITE:
  - memWrite falls immediately and state=FETCH.
  - After release, the FSM fetches normally.
